// File: rtl/loop_nest_sched_3d.sv
// loop_nest_sched_3d
// Three-level nested-loop index sequencer (column innermost, row, channel
// outermost). A pass starts on `start`, emits one (col,row,ch) tuple per
// accepted beat on a valid/ready handshake, and pulses `done` after the
// final beat is accepted. `abort` cancels a pass without `done`.
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   start, abort                  pass control
//   col_final/row_final/ch_final  inclusive last index per level, sampled at start
//   out_ready                     consumer accepts the current beat
//   out_valid                     tuple valid (high throughout RUN)
//   col_idx/row_idx/ch_idx        current indices
//   col_last/row_last/frame_last  end-of-level flags, qualified by out_valid
//   busy                          high in RUN
//   done                          one-cycle pulse after the final beat
module loop_nest_sched_3d #(
  parameter int unsigned CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] col_final,
  input  logic [CNT_WIDTH-1:0] row_final,
  input  logic [CNT_WIDTH-1:0] ch_final,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] col_idx,
  output logic [CNT_WIDTH-1:0] row_idx,
  output logic [CNT_WIDTH-1:0] ch_idx,
  output logic                 col_last,
  output logic                 row_last,
  output logic                 frame_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] col_final_q, row_final_q, ch_final_q;
  logic [CNT_WIDTH-1:0] col_final_d, row_final_d, ch_final_d;
  logic [CNT_WIDTH-1:0] col_d, row_d, ch_d;
  logic                 accept;

  // End-of-level flags from registered indices and latched finals.
  assign col_last   = out_valid & (col_idx == col_final_q);
  assign row_last   = col_last & (row_idx == row_final_q);
  assign frame_last = row_last & (ch_idx == ch_final_q);

  assign accept = out_valid & out_ready;

  // Next-state and next-index logic.
  always_comb begin
    state_d     = state_q;
    col_d       = col_idx;
    row_d       = row_idx;
    ch_d        = ch_idx;
    col_final_d = col_final_q;
    row_final_d = row_final_q;
    ch_final_d  = ch_final_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          col_final_d = col_final;
          row_final_d = row_final;
          ch_final_d  = ch_final;
          col_d       = '0;
          row_d       = '0;
          ch_d        = '0;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (abort) begin
          col_d   = '0;
          row_d   = '0;
          ch_d    = '0;
          state_d = ST_IDLE;
        end else if (accept) begin
          if (frame_last) begin
            col_d   = '0;
            row_d   = '0;
            ch_d    = '0;
            state_d = ST_DONE;
          end else if (col_idx >= col_final_q) begin
            // Column wrap carries into row, row wrap carries into channel.
            col_d = '0;
            if (row_idx >= row_final_q) begin
              row_d = '0;
              ch_d  = CNT_WIDTH'(ch_idx + 1'b1);
            end else begin
              row_d = CNT_WIDTH'(row_idx + 1'b1);
            end
          end else begin
            col_d = CNT_WIDTH'(col_idx + 1'b1);
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State, index and registered-output flops; outputs follow the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      col_idx     <= '0;
      row_idx     <= '0;
      ch_idx      <= '0;
      col_final_q <= '0;
      row_final_q <= '0;
      ch_final_q  <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx     <= col_d;
      row_idx     <= row_d;
      ch_idx      <= ch_d;
      col_final_q <= col_final_d;
      row_final_q <= row_final_d;
      ch_final_q  <= ch_final_d;
      out_valid   <= (state_d == ST_RUN);
      busy        <= (state_d == ST_RUN);
      done        <= (state_d == ST_DONE);
    end
  end

endmodule

// File: doc/loop_nest_sched_3d.md
# loop_nest_sched_3d

Three-level nested-loop scheduler that drives the column/row/channel iteration of a compute tile. Each level counts from 0 up to an inclusive final number, then wraps. The scheduler emits one index tuple per beat on a valid/ready interface and stalls on backpressure. It is the sequencer that sits in front of the address generators and MAC datapath: software/top-level FSM issues `start`, the block walks the full loop nest and pulses `done`.

## Interface
- `CNT_WIDTH`, 10, width of every loop index and final-number input

- `clk`  input  1  system clock, all state on rising edge
- `reset_n`  input  1  asynchronous, active-low reset
- `start`  input  1  single-cycle request to begin a pass; honoured only in IDLE
- `abort`  input  1  synchronous cancel; returns to IDLE without `done`
- `col_final`  input  CNT_WIDTH  inclusive last column index (innermost loop)
- `row_final`  input  CNT_WIDTH  inclusive last row index (middle loop)
- `ch_final`  input  CNT_WIDTH  inclusive last channel index (outermost loop)
- `out_ready`  input  1  consumer accepts current beat
- `out_valid`  output  1  index tuple valid
- `col_idx` / `row_idx` / `ch_idx`  output  CNT_WIDTH each  current indices
- `col_last`  output  1  `col_idx == col_final_q` while `out_valid`
- `row_last`  output  1  `col_last` and `row_idx == row_final_q`
- `frame_last`  output  1  `row_last` and `ch_idx == ch_final_q` (final beat of pass)
- `busy`  output  1  high in RUN
- `done`  output  1  one-cycle pulse after final beat accepted

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: `start`=1 and `abort`=0 → latch `col_final`, `row_final`, `ch_final` into `*_final_q`, clear all indices, go RUN. Otherwise stay.
- RUN: `out_valid`=1. Beat is accepted when `out_valid & out_ready`. On acceptance:
  - `col_idx` < `col_final_q`: col +1.
  - else col ←0; if `row_idx` < `row_final_q` row +1, else row ←0 and ch +1.
  - If `frame_last`: indices ←0, go DONE.
- No acceptance (`out_ready`=0): all indices and flags held unchanged.
- DONE: `done`=1 for exactly this cycle, `out_valid`=0, go IDLE unconditionally.
- `abort`=1 in RUN: go IDLE, indices ←0, no beat accepted that cycle, no `done`. `abort` in IDLE/DONE: no effect, except in IDLE it blocks `start`.
- `start` in RUN or DONE ignored (not queued).
- Final-number inputs are sampled only at `start`; changes during RUN have no effect.
- Comparisons are unsigned on CNT_WIDTH. The wrap compare is `>=`. An index never exceeds its latched final.
- Beats per pass = (col_final+1)·(row_final+1)·(ch_final+1). Full-scale values (all ones) are legal, with no overflow beyond wrap to 0.

## Timing
- Reset (`reset_n`=0, asynchronous): state IDLE. `out_valid`, `busy`, `done`, all flags = 0. All indices and `*_final_q` = 0.
- `start` sampled at edge N → `busy`=`out_valid`=1 from cycle N+1, with indices (0,0,0).
- `col_last`, `row_last`, `frame_last` are combinational from registered indices and latched finals. They are qualified by `out_valid`, so they are 0 outside RUN.
- Final beat accepted at edge M → `done`=1 and `busy`=0 during cycle M+1, IDLE at M+2. Earliest re-start is sampled at edge M+2.
- Throughput: one beat per cycle with `out_ready` held high. Zero bubbles across col/row/ch wrap.
- `abort` at edge K → `out_valid`=0 from cycle K+1.
- `reset_n` asserted mid-RUN: immediate return to reset values, with no `done`.

## Test plan
- Finals col=2,row=1,ch=1, `out_ready`=1 → 12 consecutive beats: (0,0,0),(1,0,0),(2,0,0),(0,1,0)…(2,1,1). `col_last` on every 3rd beat, `row_last` on beats 6 and 12, `frame_last` only on beat 12, and a `done` pulse one cycle later.
- All finals = 0 → a single beat with all three last flags = 1. `done` follows, and total busy time is 1 cycle.
- Same finals as the first test, with `out_ready` toggling 1,0,0,1,… → indices frozen while low. The sequence is identical to the first test, and the beat count is still 12.
- `abort` asserted on the 5th beat (`out_ready`=1) → `out_valid`=0 the next cycle and no `done`. A subsequent `start` restarts at (0,0,0).
- `start` re-pulsed during RUN, and `col_final` changed from 2 to 5 mid-pass → no restart, and the column still wraps at 2.
- `reset_n` low for one cycle mid-pass → all outputs 0 immediately. The block stays IDLE until the next `start`.
